// File: rtl/median_feeder.sv
// -----------------------------------------------------------------------------
// median_feeder
//
// Buffers an upstream sample stream in a small FIFO and paces it into a
// downstream median filter at one sample per two clocks. Each sample is held
// on X for a phase=0 / phase=1 pair. The filter is held in reset
// (filt_srst=1) whenever the feeder is idle. When the FIFO runs dry during a
// stream, the last sample is repeated and underrun pulses. y_strobe marks the
// cycles in which the filter's median output is valid, that is, once N
// samples have been shifted in since the filter left reset.
//
// Parameters
//   R_WIDTH   sample width in bits
//   N         window length of the downstream median filter
//   DEPTH     input FIFO depth (power of two, >= 2)
//
// Ports
//   clk        rising-edge clock
//   srst       asynchronous active-high reset
//   in_valid   upstream sample valid
//   in_ready   FIFO can accept a sample (registered, equals level != DEPTH)
//   in_data    upstream sample
//   flush      end the current stream after the current pair completes
//   X          sample presented to the filter (registered)
//   filt_srst  synchronous reset to the filter (registered)
//   phase      0 in the first cycle of a sample pair, 1 in the second
//   y_strobe   one-cycle pulse: filter output Y holds a valid median
//   underrun   one-cycle pulse: FIFO empty, the current sample gets repeated
//   level      FIFO occupancy
// -----------------------------------------------------------------------------
module median_feeder #(
  parameter int R_WIDTH = 8,
  parameter int N       = 5,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [R_WIDTH-1:0]     in_data,
  input  logic                   flush,
  output logic [R_WIDTH-1:0]     X,
  output logic                   filt_srst,
  output logic                   phase,
  output logic                   y_strobe,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N);
  localparam logic [R_WIDTH-1:0] X_ZERO = R_WIDTH'(0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      done_cnt_r;
  logic               flush_pend_r;
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [R_WIDTH-1:0] mem_r [DEPTH];

  logic               push_s;
  logic               pop_s;
  logic               nonempty_s;
  logic               pend_s;
  logic [LW-1:0]      level_nxt_s;
  logic [CW-1:0]      cnt_inc_s;
  logic [R_WIDTH-1:0] head_s;

  assign push_s     = in_valid & in_ready;
  assign nonempty_s = (level != LVL_ZERO);
  // A flush seen in the current cycle counts as pending. A flush that arrives
  // in a phase=1 cycle therefore ends the stream at the end of that cycle.
  assign pend_s     = flush_pend_r | flush;
  assign head_s     = mem_r[rd_ptr_r];

  // Pop decision: start of a stream from IDLE, or the hand-off at the end of a pair.
  always_comb begin
    pop_s = 1'b0;
    if (state_r == ST_IDLE) begin
      pop_s = nonempty_s & ~flush;
    end else begin
      pop_s = phase & nonempty_s & ~pend_s;
    end
  end

  // Next FIFO occupancy. There is no bypass, so a pop only ever sees stored data.
  always_comb begin
    level_nxt_s = level;
    if (push_s && !pop_s) begin
      level_nxt_s = level + LVL_ONE;
    end else if (!push_s && pop_s) begin
      level_nxt_s = level - LVL_ONE;
    end else begin
      level_nxt_s = level;
    end
  end

  // Saturating increment of the completed-pair counter.
  always_comb begin
    cnt_inc_s = done_cnt_r;
    if (done_cnt_r >= CNT_MAX) begin
      cnt_inc_s = CNT_MAX;
    end else begin
      cnt_inc_s = done_cnt_r + CNT_ONE;
    end
  end

  // FIFO storage. It is not reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level    <= LVL_ZERO;
      in_ready <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level    <= level_nxt_s;
      in_ready <= (level_nxt_s != LVL_FULL);
    end
  end

  // Sequencer: IDLE/RUN state, pair phase, sample register and status pulses.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_r      <= ST_IDLE;
      filt_srst    <= 1'b1;
      X            <= X_ZERO;
      phase        <= 1'b0;
      y_strobe     <= 1'b0;
      underrun     <= 1'b0;
      done_cnt_r   <= CNT_ZERO;
      flush_pend_r <= 1'b0;
    end else begin
      y_strobe <= 1'b0;
      underrun <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          filt_srst    <= 1'b1;
          phase        <= 1'b0;
          done_cnt_r   <= CNT_ZERO;
          flush_pend_r <= 1'b0;
          if (nonempty_s && !flush) begin
            state_r   <= ST_RUN;
            filt_srst <= 1'b0;
            X         <= head_s;
          end
        end
        ST_RUN: begin
          if (!phase) begin
            phase        <= 1'b1;
            flush_pend_r <= pend_s;
            // underrun belongs to the coming phase=1 cycle. That cycle
            // sees the occupancy that is being registered at this edge.
            underrun     <= (level_nxt_s == LVL_ZERO);
          end else begin
            y_strobe <= (cnt_inc_s == CNT_MAX);
            phase    <= 1'b0;
            if (pend_s) begin
              state_r      <= ST_IDLE;
              filt_srst    <= 1'b1;
              done_cnt_r   <= CNT_ZERO;
              flush_pend_r <= 1'b0;
            end else begin
              done_cnt_r <= cnt_inc_s;
              if (nonempty_s) begin
                X <= head_s;
              end
            end
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          filt_srst    <= 1'b1;
          phase        <= 1'b0;
          done_cnt_r   <= CNT_ZERO;
          flush_pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_feeder.sv
module tb_median_feeder;

  localparam int RW    = 8;
  localparam int N     = 5;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          srst;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_data;
  logic          flush;
  logic [RW-1:0] X;
  logic          filt_srst;
  logic          phase;
  logic          y_strobe;
  logic          underrun;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  median_feeder #(.R_WIDTH(RW), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .X(X), .filt_srst(filt_srst),
    .phase(phase), .y_strobe(y_strobe), .underrun(underrun), .level(level)
  );

  typedef struct {
    int x; bit ph; bit filt; bit under; bit strobe; int lvl; bit rdy; int med;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   first_med = -1;

  // Reference model: stream-level view of the feeder.
  int m_fifo[$];
  int m_hist[$];
  bit m_run, m_ph, m_pend, m_strobe;
  int m_cnt, m_x, m_med;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int median_of(int q[$]);
    int s[$];
    s = q;
    if (s.size() == 0) return -1;
    s.sort();
    return s[s.size() / 2];
  endfunction

  task automatic m_reset();
    m_fifo.delete(); m_hist.delete();
    m_run = 0; m_ph = 0; m_pend = 0; m_strobe = 0;
    m_cnt = 0; m_x = 0; m_med = 0;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic m_step(bit iv, int d, bit fl);
    bit push;
    bit nxt_strobe;
    int c;
    push = iv && (m_fifo.size() < DEPTH);
    nxt_strobe = 0;
    if (!m_run) begin
      m_cnt = 0; m_pend = 0; m_hist.delete();
      if (m_fifo.size() > 0 && !fl) begin
        m_x = m_fifo.pop_front(); m_run = 1; m_ph = 0;
      end
    end else if (!m_ph) begin
      m_pend = m_pend | fl;
      m_ph = 1;
    end else begin
      m_hist.push_back(m_x);
      if (m_hist.size() > N) void'(m_hist.pop_front());
      c = (m_cnt + 1 > N) ? N : m_cnt + 1;
      nxt_strobe = (c == N);
      if (nxt_strobe) m_med = median_of(m_hist);
      m_ph = 0;
      if (m_pend || fl) begin
        m_run = 0; m_pend = 0; m_cnt = 0;
      end else begin
        m_cnt = c;
        if (m_fifo.size() > 0) m_x = m_fifo.pop_front();
      end
    end
    m_strobe = nxt_strobe;
    if (push) m_fifo.push_back(d);
  endtask

  // Queue expectation for the current cycle, drive inputs, step the model.
  task automatic drive(bit iv, int d, bit fl);
    exp_t e;
    e.x = m_x; e.ph = m_ph; e.filt = !m_run;
    e.under = m_run && m_ph && (m_fifo.size() == 0);
    e.strobe = m_strobe; e.lvl = m_fifo.size();
    e.rdy = (m_fifo.size() < DEPTH); e.med = m_med;
    exp_q.push_back(e);
    in_valid = iv; in_data = d[RW-1:0]; flush = fl;
    m_step(iv, d, fl);
  endtask

  task automatic cycle(bit iv, int d, bit fl);
    @(posedge clk); #1;
    drive(iv, d, fl);
  endtask

  // Raise flush for exactly one cycle at a RUN phase=0 cycle.
  task automatic flush_at_phase0();
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (phase === 1'b0 && filt_srst === 1'b0) begin
        drive(0, 0, 1); done = 1;
      end else begin
        drive(0, 0, 0);
      end
    end
    check("flush_phase0_found", done, 1);
  endtask

  // Monitor: compare every scheduled cycle, plus a behavioural filter window.
  int   win[$];
  exp_t e_mon;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check("X", X, e_mon.x);
      check("phase", phase, e_mon.ph);
      check("filt_srst", filt_srst, e_mon.filt);
      check("underrun", underrun, e_mon.under);
      check("y_strobe", y_strobe, e_mon.strobe);
      check("level", level, e_mon.lvl);
      check("in_ready", in_ready, e_mon.rdy);
      if (y_strobe === 1'b1 && e_mon.strobe) begin
        check("median", median_of(win), e_mon.med);
        if (first_med < 0) first_med = median_of(win);
      end
    end
    if (filt_srst !== 1'b0) begin
      win.delete();
    end else if (phase === 1'b1) begin
      win.push_back(int'(X));
      if (win.size() > N) void'(win.pop_front());
    end
  end

  initial begin
    bit found;
    m_reset();
    srst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    #2;
    check("rst_X", X, 0);
    check("rst_filt_srst", filt_srst, 1);
    check("rst_phase", phase, 0);
    check("rst_y_strobe", y_strobe, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1; srst = 1'b0;
    drive(0, 0, 0);

    // Prime and run: 10..60 back-to-back; first strobe carries median 30.
    for (int i = 1; i <= 6; i++) cycle(1, 10 * i, 0);
    repeat (18) cycle(0, 0, 0);
    check("first_median", first_med, 30);
    flush_at_phase0();
    repeat (6) cycle(0, 0, 0);

    // Underrun: only three samples, the last one keeps repeating.
    cycle(1, 7, 0); cycle(1, 8, 0); cycle(1, 9, 0);
    repeat (16) cycle(0, 0, 0);
    flush_at_phase0();
    repeat (4) cycle(0, 0, 0);

    // Full FIFO while flush holds the feeder in IDLE.
    for (int i = 0; i < 6; i++) cycle(1, 100 + i, 1);
    check("full_in_ready", in_ready, 0);
    check("full_level", level, DEPTH);
    repeat (14) cycle(0, 0, 0);
    flush_at_phase0();
    repeat (3) cycle(0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 255), $urandom_range(0, 99) < 4);

    // Asynchronous reset in the middle of a stream.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (filt_srst === 1'b0) found = 1;
      else drive(1, $urandom_range(0, 255), 0);
    end
    check("run_before_reset", found, 1);
    #2;
    srst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    exp_q.delete();
    m_reset();
    #1;
    check("arst_X", X, 0);
    check("arst_filt_srst", filt_srst, 1);
    check("arst_phase", phase, 0);
    check("arst_y_strobe", y_strobe, 0);
    check("arst_underrun", underrun, 0);
    check("arst_level", level, 0);
    check("arst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1; srst = 1'b0;
    drive(0, 0, 0);
    for (int i = 0; i < 60; i++)
      cycle($urandom_range(0, 99) < 50, $urandom_range(0, 255), $urandom_range(0, 99) < 3);
    repeat (4) cycle(0, 0, 0);
    @(negedge clk); #1;
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
